// File: rtl/dtcm_bank_if.sv
// LSU <-> DTCM bank signal bundle; force_parity_flip exists only with DTCM_PARITY_EN.
`timescale 1ns/1ps
interface dtcm_bank_if;
    logic        we;
    logic        re;
    logic [1:0]  data_width;
    logic [31:0] addr_write;
    logic [31:0] write_data;
    logic [31:0] addr_read;
    logic [31:0] read_data;
    logic        read_valid;
    logic        misaligned_w;
    logic        misaligned_r;
    logic        parity_err;
`ifdef DTCM_PARITY_EN
    logic        force_parity_flip;
`endif

    modport master (
`ifdef DTCM_PARITY_EN
        output force_parity_flip,
`endif
        output we, re, data_width, addr_write, write_data, addr_read,
        input  read_data, read_valid, misaligned_w, misaligned_r, parity_err
    );

    modport slave (
`ifdef DTCM_PARITY_EN
        input  force_parity_flip,
`endif
        input  we, re, data_width, addr_write, write_data, addr_read,
        output read_data, read_valid, misaligned_w, misaligned_r, parity_err
    );
endinterface

// File: rtl/dtcm_bank.sv
// Data TCM bank: byte-lane write merge, zero-filled right-justified reads, optional lane parity (DTCM_PARITY_EN).
// Writes commit at the MEMEX edge, reads return one cycle later; one access per cycle, never stalls.
`timescale 1ns/1ps
module dtcm_bank #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
    parameter int          DEPTH_WORDS = 4096
) (
    input  logic       clk,
    input  logic       rst,
    dtcm_bank_if.slave bus
);
    localparam int AW = $clog2(DEPTH_WORDS);

    function automatic logic is_aligned(input logic [1:0] width, input logic [1:0] lane);
        case (width)
            2'b00:   is_aligned = 1'b1;
            2'b01:   is_aligned = ~lane[0];
            default: is_aligned = (lane == 2'b00);
        endcase
    endfunction

    function automatic logic [3:0] lane_mask(input logic [1:0] width, input logic [1:0] lane);
        case (width)
            2'b00:   lane_mask = 4'b0001 << lane;
            2'b01:   lane_mask = 4'b0011 << lane;
            default: lane_mask = 4'b1111;
        endcase
    endfunction

    logic [31:0]   mem_q [DEPTH_WORDS];

    logic [31:0]   woff, roff;
    logic [AW-1:0] widx, ridx;
    logic [1:0]    wlane, rlane;
    logic          unused_addr_bits;

    assign woff  = bus.addr_write - BASE_ADDR;
    assign roff  = bus.addr_read - BASE_ADDR;
    assign widx  = woff[AW+1:2];
    assign ridx  = roff[AW+1:2];
    assign wlane = woff[1:0];
    assign rlane = roff[1:0];
    assign unused_addr_bits = ^{woff[31:AW+2], roff[31:AW+2]};

    logic        w_ok, r_ok;
    logic [3:0]  wbe, rbe;
    logic [31:0] wword;
    logic [31:0] rword;
    logic [31:0] rshift;
    logic [31:0] rext;

    // Write data is replicated across lanes so the byte enables alone pick placement.
    always_comb begin
        w_ok  = is_aligned(bus.data_width, wlane);
        wbe   = 4'b0000;
        wword = bus.write_data;
        if (bus.we && w_ok && !rst) begin
            wbe = lane_mask(bus.data_width, wlane);
        end
        case (bus.data_width)
            2'b00:   wword = {4{bus.write_data[7:0]}};
            2'b01:   wword = {2{bus.write_data[15:0]}};
            default: wword = bus.write_data;
        endcase
    end

    // Same-word write in the same cycle is forwarded lane by lane (write-first).
    always_comb begin
        r_ok  = is_aligned(bus.data_width, rlane);
        rbe   = lane_mask(bus.data_width, rlane);
        rword = mem_q[ridx];
        for (int l = 0; l < 4; l++) begin
            if (wbe[l] && (widx == ridx)) begin
                rword[8*l +: 8] = wword[8*l +: 8];
            end
        end
        rshift = rword >> {rlane, 3'b000};
        case (bus.data_width)
            2'b00:   rext = {24'b0, rshift[7:0]};
            2'b01:   rext = {16'b0, rshift[15:0]};
            default: rext = rword;
        endcase
    end

    always_ff @(posedge clk) begin
        for (int l = 0; l < 4; l++) begin
            if (wbe[l]) begin
                mem_q[widx][8*l +: 8] <= wword[8*l +: 8];
            end
        end
    end

    logic [31:0] rd_data_q, rd_data_d;
    logic        rd_vld_q, rd_vld_d;
    logic        mis_w_q, mis_w_d;
    logic        mis_r_q, mis_r_d;

`ifdef DTCM_PARITY_EN
    logic [3:0] par_q [DEPTH_WORDS];
    logic [3:0] wpar, rpar, rcalc;
    logic       perr_q, perr_d;

    always_comb begin
        rpar  = par_q[ridx];
        wpar  = 4'b0000;
        rcalc = 4'b0000;
        for (int l = 0; l < 4; l++) begin
            wpar[l] = ^wword[8*l +: 8];
            if (wbe[l] && (widx == ridx)) begin
                rpar[l] = wpar[l] ^ ((l == 0) && bus.force_parity_flip);
            end
            rcalc[l] = ^rword[8*l +: 8];
        end
        wpar[0] = wpar[0] ^ bus.force_parity_flip;
        perr_d  = bus.re && r_ok && (|(rbe & (rcalc ^ rpar)));
    end

    always_ff @(posedge clk) begin
        for (int l = 0; l < 4; l++) begin
            if (wbe[l]) begin
                par_q[widx][l] <= wpar[l];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) perr_q <= 1'b0;
        else     perr_q <= perr_d;
    end

    assign bus.parity_err = perr_q;
`else
    assign bus.parity_err = 1'b0;
`endif

    always_comb begin
        rd_vld_d  = bus.re;
        mis_r_d   = bus.re && !r_ok;
        mis_w_d   = bus.we && !is_aligned(bus.data_width, wlane);
        rd_data_d = rd_data_q;
        if (bus.re) begin
            rd_data_d = r_ok ? rext : 32'h0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q <= 32'h0;
            rd_vld_q  <= 1'b0;
            mis_w_q   <= 1'b0;
            mis_r_q   <= 1'b0;
        end else begin
            rd_data_q <= rd_data_d;
            rd_vld_q  <= rd_vld_d;
            mis_w_q   <= mis_w_d;
            mis_r_q   <= mis_r_d;
        end
    end

    assign bus.read_data    = rd_data_q;
    assign bus.read_valid   = rd_vld_q;
    assign bus.misaligned_w = mis_w_q;
    assign bus.misaligned_r = mis_r_q;
endmodule

// File: tb/tb_dtcm_bank.sv
// Directed bench for dtcm_bank: merge, alignment, write-first, reset and optional parity behaviour.
`timescale 1ns/1ps
module tb_dtcm_bank;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dtcm_bank_if bus();
    dtcm_bank dut (.clk(clk), .rst(rst), .bus(bus));

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] w, input logic [31:0] a, input logic [31:0] d);
        bus.we = 1'b1; bus.data_width = w; bus.addr_write = a; bus.write_data = d;
        tick();
        bus.we = 1'b0;
    endtask

    task automatic rd(input logic [1:0] w, input logic [31:0] a);
        bus.re = 1'b1; bus.data_width = w; bus.addr_read = a;
        tick();
        bus.re = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus.we = 1'b0; bus.re = 1'b0; bus.data_width = 2'b10;
        bus.addr_write = 32'h1000; bus.write_data = 32'h0; bus.addr_read = 32'h1000;
`ifdef DTCM_PARITY_EN
        bus.force_parity_flip = 1'b0;
`endif
        #2;
        check_eq("rst_read_data",  bus.read_data, 32'h0);
        check_eq("rst_read_valid", {31'b0, bus.read_valid}, 32'h0);
        check_eq("rst_mis_w",      {31'b0, bus.misaligned_w}, 32'h0);
        check_eq("rst_mis_r",      {31'b0, bus.misaligned_r}, 32'h0);
        check_eq("rst_perr",       {31'b0, bus.parity_err}, 32'h0);
        tick();
        rst = 1'b0;
        tick();

        // Word write then byte read of the top lane.
        wr(2'b10, 32'h1000, 32'hDEADBEEF);
        rd(2'b00, 32'h1003);
        check_eq("byte_rd_data",  bus.read_data, 32'h0000_00DE);
        check_eq("byte_rd_valid", {31'b0, bus.read_valid}, 32'h1);
        check_eq("byte_rd_perr",  {31'b0, bus.parity_err}, 32'h0);
        tick();
        check_eq("idle_valid_low", {31'b0, bus.read_valid}, 32'h0);
        check_eq("idle_data_hold", bus.read_data, 32'h0000_00DE);

        // Short merge into an existing word, then back-to-back reads.
        wr(2'b10, 32'h1004, 32'hAABBCCDD);
        wr(2'b01, 32'h1006, 32'h0000_1234);
        bus.re = 1'b1; bus.data_width = 2'b10; bus.addr_read = 32'h1004;
        tick();
        check_eq("short_merge_word", bus.read_data, 32'h1234CCDD);
        bus.data_width = 2'b01; bus.addr_read = 32'h1006;
        tick();
        check_eq("b2b_short_hi", bus.read_data, 32'h0000_1234);
        check_eq("b2b_valid", {31'b0, bus.read_valid}, 32'h1);
        bus.data_width = 2'b00; bus.addr_read = 32'h1005;
        tick();
        check_eq("b2b_byte_lane1", bus.read_data, 32'h0000_00CC);
        bus.re = 1'b0;

        // Misaligned store is dropped and flagged for one cycle only.
        wr(2'b01, 32'h1001, 32'h0000_5555);
        check_eq("mis_w_pulse", {31'b0, bus.misaligned_w}, 32'h1);
        tick();
        check_eq("mis_w_clear", {31'b0, bus.misaligned_w}, 32'h0);
        rd(2'b10, 32'h1000);
        check_eq("mis_w_no_change", bus.read_data, 32'hDEADBEEF);
        check_eq("aligned_mis_r",   {31'b0, bus.misaligned_r}, 32'h0);
        rd(2'b10, 32'h1002);
        check_eq("mis_r_data",  bus.read_data, 32'h0);
        check_eq("mis_r_flag",  {31'b0, bus.misaligned_r}, 32'h1);
        check_eq("mis_r_valid", {31'b0, bus.read_valid}, 32'h1);

        // Same-cycle write and read on one word: the written lane reads new, others old.
        wr(2'b10, 32'h2000, 32'h11223344);
        bus.we = 1'b1; bus.re = 1'b1; bus.data_width = 2'b00;
        bus.addr_write = 32'h2001; bus.write_data = 32'h0000_0077; bus.addr_read = 32'h2001;
        tick();
        check_eq("wf_same_lane", bus.read_data, 32'h0000_0077);
        bus.addr_write = 32'h2002; bus.write_data = 32'h0000_0099; bus.addr_read = 32'h2003;
        tick();
        check_eq("wf_other_lane", bus.read_data, 32'h0000_0011);
        bus.we = 1'b0; bus.re = 1'b0;
        rd(2'b10, 32'h2000);
        check_eq("wf_merged_word", bus.read_data, 32'h11997744);

        // Width code 2'b11 behaves as word; top word of the window.
        wr(2'b11, 32'h4FFC, 32'h89ABCDEF);
        rd(2'b11, 32'h4FFC);
        check_eq("w11_top_word", bus.read_data, 32'h89ABCDEF);
        rd(2'b11, 32'h4FFE);
        check_eq("w11_misaligned", {31'b0, bus.misaligned_r}, 32'h1);

        // Reset with a read in flight drops outputs without a clock edge.
        bus.re = 1'b1; bus.data_width = 2'b10; bus.addr_read = 32'h1000;
        tick();
        check_eq("pre_rst_valid", {31'b0, bus.read_valid}, 32'h1);
        bus.re = 1'b0;
        rst = 1'b1;
        #1;
        check_eq("async_rst_valid", {31'b0, bus.read_valid}, 32'h0);
        check_eq("async_rst_data",  bus.read_data, 32'h0);
        bus.we = 1'b1; bus.data_width = 2'b10; bus.addr_write = 32'h1000; bus.write_data = 32'h0BADF00D;
        tick();
        bus.we = 1'b0;
        rst = 1'b0;
        tick();
        rd(2'b10, 32'h1000);
        check_eq("mem_survives_rst", bus.read_data, 32'hDEADBEEF);

`ifdef DTCM_PARITY_EN
        bus.force_parity_flip = 1'b1;
        wr(2'b10, 32'h1000, 32'hDEADBEEF);
        bus.force_parity_flip = 1'b0;
        rd(2'b00, 32'h1000);
        check_eq("par_flip_err",  {31'b0, bus.parity_err}, 32'h1);
        check_eq("par_flip_data", bus.read_data, 32'h0000_00EF);
        rd(2'b00, 32'h1001);
        check_eq("par_lane1_ok",  {31'b0, bus.parity_err}, 32'h0);
`else
        rd(2'b00, 32'h1000);
        check_eq("perr_tied_low", {31'b0, bus.parity_err}, 32'h0);
        check_eq("lane0_byte",    bus.read_data, 32'h0000_00EF);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
